// File: rtl/div4_pkg.sv
// Shared definitions for the 4-bit sequential restoring divider.
// The states, the width and iteration constants and the result reset values
// live here so the controller and the datapath agree on them.
package div4_pkg;

  localparam int DIV4_W    = 4;
  localparam int DIV4_ITER = 4;

  // Step counter value of the last RUN iteration.
  localparam logic [1:0] CNT_LAST = 2'(DIV4_ITER - 1);

  // Values the quotient and remainder registers take in reset.
  localparam logic [DIV4_W-1:0] QUOT_RST = '0;
  localparam logic [DIV4_W-1:0] REM_RST  = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div4_state_e;

endpackage

// File: rtl/addSub4bit.sv
// Shared 4-bit adder/subtractor datapath.
// op = 0: sum = a + b.  op = 1: sum = a - b, computed as a + ~b + 1.
// When subtracting, cout = 1 means no borrow (a >= b).
module addSub4bit
  import div4_pkg::*;
(
  input  logic [DIV4_W-1:0] a,
  input  logic [DIV4_W-1:0] b,
  input  logic              op,
  output logic [DIV4_W-1:0] sum,
  output logic              cout
);

  logic [DIV4_W-1:0] b_x;

  // Invert b for subtraction; op also supplies the +1 carry-in.
  assign b_x = b ^ {DIV4_W{op}};

  // One wide add yields both the 4-bit result and its carry-out.
  assign {cout, sum} = {1'b0, a} + {1'b0, b_x} + {{DIV4_W{1'b0}}, op};

endmodule

// File: rtl/div4_seq_ctrl.sv
// Sequencing controller for a 4-bit unsigned restoring divider built on the
// shared addSub4bit datapath: one trial subtraction per clock, four
// iterations, start/done handshake toward the requester.
//
// Optional feature, macro DIV4_ZERO_CHECK_EN:
//   defined   - a zero divisor skips the iterations, reports done one cycle
//               after acceptance and raises div_zero.
//   undefined - a zero divisor runs the normal four iterations (same
//               quotient/remainder values) and div_zero is tied low.
module div4_seq_ctrl
  import div4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIV4_W-1:0] dividend,
  input  logic [DIV4_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DIV4_W-1:0] quotient,
  output logic [DIV4_W-1:0] remainder,
  output logic              div_zero
);

  div4_state_e       state_q, state_d;
  logic [DIV4_W-1:0] a_q, a_d;       // partial remainder
  logic [DIV4_W-1:0] q_q, q_d;       // dividend bits shifting into quotient
  logic [DIV4_W-1:0] m_q, m_d;       // divisor
  logic [1:0]        cnt_q, cnt_d;   // iteration counter
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DIV4_W-1:0] quot_q, quot_d;
  logic [DIV4_W-1:0] rem_q, rem_d;
`ifdef DIV4_ZERO_CHECK_EN
  logic              dz_q, dz_d;
`endif

  // One restoring step: shift {A,Q} left, try A - M, keep or restore.
  logic              msb;
  logic [DIV4_W-1:0] sh_a;
  logic [DIV4_W-1:0] diff;
  logic              cout;
  logic              success;
  logic [DIV4_W-1:0] next_a;
  logic [DIV4_W-1:0] next_q;

  assign msb  = a_q[DIV4_W-1];
  assign sh_a = {a_q[DIV4_W-2:0], q_q[DIV4_W-1]};

  addSub4bit u_addsub (
    .a    (sh_a),
    .b    (m_q),
    .op   (1'b1),
    .sum  (diff),
    .cout (cout)
  );

  // A set msb means the shifted remainder is at least 16 > M, so the
  // subtraction always succeeds; the 4-bit diff is still exact then.
  assign success = msb | cout;
  assign next_a  = success ? diff : sh_a;
  assign next_q  = {q_q[DIV4_W-2:0], success};

  // Next-state and next-register computation for the whole controller.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; a missing default would infer a latch.
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef DIV4_ZERO_CHECK_EN
    dz_d    = dz_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        busy_d = 1'b0;
        if (start) begin
          a_d   = '0;
          q_d   = dividend;
          m_d   = divisor;
          cnt_d = '0;
`ifdef DIV4_ZERO_CHECK_EN
          dz_d  = 1'b0;
          if (divisor == '0) begin
            // Short-cut: report the algorithm's own zero-divisor answer.
            state_d = DONE;
            done_d  = 1'b1;
            quot_d  = '1;
            rem_d   = dividend;
            dz_d    = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
          end
`else
          state_d = RUN;
          busy_d  = 1'b1;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        // start and the operand inputs are deliberately not looked at here.
        a_d   = next_a;
        q_d   = next_q;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quot_d  = next_q;
          rem_d   = next_a;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= QUOT_RST;
      rem_q   <= REM_RST;
`ifdef DIV4_ZERO_CHECK_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
`ifdef DIV4_ZERO_CHECK_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
`ifdef DIV4_ZERO_CHECK_EN
  assign div_zero  = dz_q;
`else
  assign div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_div4_seq_ctrl.sv
// Self-checking bench for div4_seq_ctrl. Expected results come from plain
// integer division; latency and div_zero expectations follow the
// DIV4_ZERO_CHECK_EN build option.
module tb_div4_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_zero;

  int total = 0;
  int bad   = 0;

  div4_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [3:0] ref_q(input int dd, input int dv);
    return (dv == 0) ? 4'hF : 4'(dd / dv);
  endfunction

  function automatic logic [3:0] ref_r(input int dd, input int dv);
    return (dv == 0) ? 4'(dd) : 4'(dd % dv);
  endfunction

  // Number of clock edges from acceptance to the cycle showing done.
  function automatic int ref_lat(input int dv);
`ifdef DIV4_ZERO_CHECK_EN
    return (dv == 0) ? 1 : 5;
`else
    return (dv == 0) ? 5 : 5;
`endif
  endfunction

  function automatic int ref_busy(input int dv);
`ifdef DIV4_ZERO_CHECK_EN
    return (dv == 0) ? 0 : 4;
`else
    return (dv == 0) ? 4 : 4;
`endif
  endfunction

  function automatic logic ref_dz(input int dv);
`ifdef DIV4_ZERO_CHECK_EN
    return dv == 0;
`else
    return (dv == 0) && 1'b0;
`endif
  endfunction

  // Issue one request (called at a negedge) and watch until done or timeout.
  // Returns at the negedge where done was seen. lat=0 means timeout.
  task automatic run_op(input logic [3:0] dd, input logic [3:0] dv,
                        output int lat, output int busy_n,
                        output logic [3:0] qo, output logic [3:0] ro,
                        output logic dzo, output logic overlap);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 4'($urandom_range(0, 15));
    divisor  = 4'($urandom_range(0, 15));
    lat = 0; busy_n = 0; overlap = 1'b0; qo = 'x; ro = 'x; dzo = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      if (busy === 1'b1) busy_n++;
      if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
      if (done === 1'b1) begin
        lat = n; qo = quotient; ro = remainder; dzo = div_zero;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Compare one finished operation against the model.
  task automatic check_op(input string tag, input logic [3:0] dd, input logic [3:0] dv,
                          input int lat, input int busy_n, input logic [3:0] qo,
                          input logic [3:0] ro, input logic dzo, input logic overlap);
    total++;
    if (lat !== ref_lat(dv)) begin
      bad++;
      $display("FAIL %s latency %0d/%0d: got %0d want %0d", tag, dd, dv, lat, ref_lat(dv));
    end
    total++;
    if (qo !== ref_q(dd, dv)) begin
      bad++;
      $display("FAIL %s quotient %0d/%0d: got %0d want %0d", tag, dd, dv, qo, ref_q(dd, dv));
    end
    total++;
    if (ro !== ref_r(dd, dv)) begin
      bad++;
      $display("FAIL %s remainder %0d/%0d: got %0d want %0d", tag, dd, dv, ro, ref_r(dd, dv));
    end
    total++;
    if (dzo !== ref_dz(dv)) begin
      bad++;
      $display("FAIL %s div_zero %0d/%0d: got %b want %b", tag, dd, dv, dzo, ref_dz(dv));
    end
    total++;
    if (busy_n != ref_busy(dv) || overlap !== 1'b0) begin
      bad++;
      $display("FAIL %s busy %0d/%0d: got %0d cycles overlap=%b want %0d cycles overlap=0",
               tag, dd, dv, busy_n, overlap, ref_busy(dv));
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      total++;
      if ({busy, done, quotient, remainder, div_zero} !== 11'b0) begin
        bad++;
        $display("FAIL reset_values cycle %0d: got busy=%b done=%b q=%h r=%h dz=%b want all 0",
                 c, busy, done, quotient, remainder, div_zero);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_basic;
    int lat, bn; logic [3:0] qo, ro; logic dzo, ov;
    run_op(4'd13, 4'd3, lat, bn, qo, ro, dzo, ov);
    check_op("basic_13_3", 4'd13, 4'd3, lat, bn, qo, ro, dzo, ov);
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse_width: got done=%b want 0", done);
    end
    total++;
    if (quotient !== 4'd4 || remainder !== 4'd1) begin
      bad++;
      $display("FAIL result_hold: got q=%0d r=%0d want q=4 r=1", quotient, remainder);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bn; logic [3:0] qo, ro; logic dzo, ov;
    run_op(4'd15, 4'd1, lat, bn, qo, ro, dzo, ov);
    check_op("b2b_15_1", 4'd15, 4'd1, lat, bn, qo, ro, dzo, ov);
    // Called at the DONE negedge: start is high for the DONE cycle.
    run_op(4'd7, 4'd9, lat, bn, qo, ro, dzo, ov);
    check_op("b2b_7_9", 4'd7, 4'd9, lat, bn, qo, ro, dzo, ov);
  endtask

  task automatic test_div_zero;
    int lat, bn; logic [3:0] qo, ro; logic dzo, ov;
    run_op(4'd14, 4'd0, lat, bn, qo, ro, dzo, ov);
    check_op("divzero_14_0", 4'd14, 4'd0, lat, bn, qo, ro, dzo, ov);
    // A following non-zero division must clear div_zero.
    run_op(4'd8, 4'd2, lat, bn, qo, ro, dzo, ov);
    check_op("after_divzero_8_2", 4'd8, 4'd2, lat, bn, qo, ro, dzo, ov);
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int lat; logic [3:0] qo, ro;
    dividend = 4'd12; divisor = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; qo = 'x; ro = 'x;
    for (int n = 1; n <= 20; n++) begin
      start = (n == 2);
      if (n == 2) begin dividend = 4'd9; divisor = 4'd2; end
      if (done === 1'b1) begin lat = n; qo = quotient; ro = remainder; start = 1'b0; break; end
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if (lat != 5 || qo !== 4'd2 || ro !== 4'd2) begin
      bad++;
      $display("FAIL ignore_start_in_run: got lat=%0d q=%0d r=%0d want lat=5 q=2 r=2", lat, qo, ro);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_done: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat, bn, seen; logic [3:0] qo, ro; logic dzo, ov;
    dividend = 4'd11; divisor = 4'd3; start = 1'b1;
    @(negedge clk);            // edge k passed
    start = 1'b0;
    repeat (2) @(negedge clk); // now in the 3rd RUN cycle
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);            // cycle after reset deasserts
    total++;
    if ({busy, done, quotient, remainder, div_zero} !== 11'b0) begin
      bad++;
      $display("FAIL reset_mid_run_values: got busy=%b done=%b q=%h r=%h dz=%b want all 0",
               busy, done, quotient, remainder, div_zero);
    end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      @(negedge clk);
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_mid_run_no_done: got %0d active cycles want 0", seen);
    end
    run_op(4'd6, 4'd4, lat, bn, qo, ro, dzo, ov);
    check_op("after_reset_6_4", 4'd6, 4'd4, lat, bn, qo, ro, dzo, ov);
    @(negedge clk);
  endtask

  task automatic test_random;
    int lat, bn; logic [3:0] qo, ro, dd, dv; logic dzo, ov;
    for (int i = 0; i < 40; i++) begin
      dd = 4'($urandom_range(0, 15));
      dv = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      run_op(dd, dv, lat, bn, qo, ro, dzo, ov);
      check_op("random", dd, dv, lat, bn, qo, ro, dzo, ov);
      // Mix back-to-back requests with idle gaps.
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignore_start();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div4_seq_ctrl.md
# div4_seq_ctrl

Multi-cycle controller that sequences the shared 4-bit adder/subtractor datapath (`addSub4bit`) as an unsigned restoring divider. One subtraction is performed per clock over four iterations, with a start/done handshake toward the requester. It sits directly above the `addSub4bit` instance and owns all operand and partial-remainder registers.

## Interface

- No parameters: width is fixed at 4 bits and set by the datapath.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  synchronous, active-low reset.
- `start`  input  1  request pulse; sampled only in IDLE or DONE.
- `dividend`  input  4  unsigned dividend; sampled with `start`.
- `divisor`  input  4  unsigned divisor; sampled with `start`.
- `busy`  output  1  high while iterating.
- `done`  output  1  one-cycle pulse when results become valid.
- `quotient`  output  4  result; held until the next accepted `start`.
- `remainder`  output  4  result; held until the next accepted `start`.
- `div_zero`  output  1  divisor-zero flag; valid with `done` and held with the results.

## Operation

- States:
  - IDLE: wait for `start`.
  - RUN: 4 iterations, 2-bit step counter 0..3.
  - DONE: 1 cycle, `done`=1.
- Registers:
  - A[3:0]: partial remainder.
  - Q[3:0]: dividend shifting into quotient.
  - M[3:0]: divisor.
  - cnt[1:0]: step counter.
- Accept:
  - In IDLE or DONE with `start`=1: A←0, Q←dividend, M←divisor, cnt←0, go to RUN.
  - `start` in RUN is ignored; inputs are not sampled.
- Each RUN cycle:
  - Shift {A,Q} left by one; the bit shifted out of A is `msb`.
  - The datapath computes `shA[3:0]` − M with op tied to 1.
  - Success when `msb`=1 or `Cout`=1 (no borrow).
  - On success: A←sum, Q[0]←1.
  - On failure: A←shA (restore), Q[0]←0.
  - The sum is always correct in 4 bits, because the true difference is less than M ≤ 15.
- Leaving RUN: after cnt=3, latch quotient←Q and remainder←A, then go to DONE.
- DONE returns to IDLE next cycle unless `start`=1, which permits back-to-back operation.
- Divisor 0 with the algorithm alone yields quotient 4'hF and remainder = dividend.

## Timing

- Reset values: state IDLE; `busy`=0, `done`=0, `div_zero`=0; quotient=0, remainder=0. A, Q, M and cnt are cleared.
- Reset mid-RUN: the next cycle is IDLE with all outputs at reset values. No `done` is issued for the aborted operation.
- Latency (`start` sampled at edge k):
  - `busy`=1 in the 4 cycles following edges k..k+3.
  - Results are registered at edge k+4.
  - `done`=1 in the cycle following edge k+4.
- Throughput: one division per 5 cycles.
- `busy` and `done` are never high together.

## Configuration

- Macro: `DIV4_ZERO_CHECK_EN`.
- Defined:
  - Accepting `start` with divisor=0 skips RUN and goes straight to DONE.
  - `done` asserts in the cycle after edge k.
  - `div_zero`=1, quotient=4'hF, remainder=dividend.
  - `div_zero` is cleared on the next accepted `start`.
- Undefined:
  - Divisor=0 runs the full 4 iterations.
  - Quotient and remainder values are identical to the defined case; latency is the normal 5 cycles.
  - `div_zero` is tied to 0.

## Structure

- Shared package `div4_pkg`:
  - State enum: IDLE, RUN, DONE.
  - Constants `DIV4_W`=4 and `DIV4_ITER`=4.
  - Reset values for quotient and remainder.
- One sub-module: an `addSub4bit` instance with op tied to 1, operand a = shifted A, operand b = M. All sequencing, restore and quotient logic stay in `div4_seq_ctrl`.

## Test plan

- Reset, then 13÷3 → `done` in the cycle after edge k+4; quotient=4, remainder=1, `div_zero`=0, `busy` high for exactly 4 cycles.
- 15÷1 and 7÷9 back-to-back, with `start` asserted in the DONE cycle → quotient=15, remainder=0, then quotient=0, remainder=7; no idle gap.
- 14÷0:
  - With `DIV4_ZERO_CHECK_EN`: `done` in the cycle after edge k, `div_zero`=1, quotient=4'hF, remainder=14.
  - Without it: `done` after 5 cycles, same values, `div_zero`=0.
- Pulse `start` with new operands (9÷2) during RUN of 12÷5 → ignored; result is quotient=2, remainder=2.
- Assert `rst_n`=0 during the 3rd RUN cycle → no `done` is issued; all outputs are at reset values in the cycle after reset deasserts. A subsequent 6÷4 gives quotient=1, remainder=2.
